// File: rtl/pwm_duty_sequencer.sv
// Duty/dead-time sequencer for the complementary PWM generator: clamps PID targets,
// slew-limits duty once per PWM period, runs soft-start/soft-stop and forces off on fault.
module pwm_duty_sequencer #(
  parameter logic [9:0] DUTY_MIN = 10'd100,
  parameter logic [9:0] DUTY_MAX = 10'd500,
  parameter logic [9:0] STEP     = 10'd4,
  parameter logic [8:0] DT_MAX   = 9'd82
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       fault,
  input  logic       fault_clear,
  input  logic       period_start,
  input  logic [9:0] target_duty,
  input  logic       target_valid,
  output logic       target_ready,
  input  logic [8:0] dead_time_cfg,
  output logic [9:0] duty_data,
  output logic [8:0] dead_time,
  output logic       pwm_en,
  output logic [2:0] state,
  output logic       fault_latched
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SOFTSTART = 3'd1,
    RUN       = 3'd2,
    SHUTDOWN  = 3'd3,
    FAULT     = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] duty_q, duty_d;
  logic [8:0] dt_q, dt_d;
  logic       pwm_en_q, pwm_en_d;
  logic [9:0] tgt_q, tgt_d;
  logic [9:0] tgt_clamped;
  logic [8:0] dt_clamped;
  logic [9:0] step_v;

  // Signed 11-bit difference keeps the comparison free of unsigned wrap.
  function automatic logic [9:0] slew(input logic [9:0] cur, input logic [9:0] goal);
    logic signed [10:0] diff;
    diff = $signed({1'b0, goal}) - $signed({1'b0, cur});
    if (diff > $signed({1'b0, STEP}))        return cur + STEP;
    else if (diff < -$signed({1'b0, STEP}))  return cur - STEP;
    else                                     return goal;
  endfunction

  assign tgt_clamped = (target_duty < DUTY_MIN) ? DUTY_MIN :
                       (target_duty > DUTY_MAX) ? DUTY_MAX : target_duty;
  assign dt_clamped  = (dead_time_cfg > DT_MAX) ? DT_MAX : dead_time_cfg;

  assign target_ready  = (state_q != FAULT) && !fault;
  assign duty_data     = duty_q;
  assign dead_time     = dt_q;
  assign pwm_en        = pwm_en_q;
  assign state         = state_q;
  assign fault_latched = (state_q == FAULT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      dt_q     <= '0;
      pwm_en_q <= 1'b0;
      tgt_q    <= DUTY_MIN;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      dt_q     <= dt_d;
      pwm_en_q <= pwm_en_d;
      tgt_q    <= tgt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    dt_d     = dt_q;
    pwm_en_d = pwm_en_q;
    tgt_d    = tgt_q;
    step_v   = '0;

    if (target_valid && target_ready) tgt_d = tgt_clamped;

    if (fault) begin
      state_d  = FAULT;
      duty_d   = '0;
      dt_d     = '0;
      pwm_en_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          duty_d   = '0;
          dt_d     = '0;
          pwm_en_d = 1'b0;
          if (enable) state_d = SOFTSTART;
        end
        SOFTSTART: begin
          if (period_start) begin
            // pwm_en still low means this is the first period since IDLE
            step_v   = pwm_en_q ? slew(duty_q, tgt_q) : DUTY_MIN;
            duty_d   = step_v;
            dt_d     = dt_clamped;
            pwm_en_d = 1'b1;
            if (step_v == tgt_q) state_d = RUN;
          end
          if (!enable) state_d = pwm_en_d ? SHUTDOWN : IDLE;
        end
        RUN: begin
          if (period_start) begin
            duty_d = slew(duty_q, tgt_q);
            dt_d   = dt_clamped;
          end
          if (!enable) state_d = SHUTDOWN;
        end
        SHUTDOWN: begin
          if (enable) begin
            state_d = SOFTSTART;
            if (period_start) begin
              step_v = slew(duty_q, tgt_q);
              duty_d = step_v;
              dt_d   = dt_clamped;
              if (step_v == tgt_q) state_d = RUN;
            end
          end else if (period_start) begin
            if (duty_q == DUTY_MIN) begin
              state_d  = IDLE;
              duty_d   = '0;
              dt_d     = '0;
              pwm_en_d = 1'b0;
            end else begin
              duty_d = slew(duty_q, DUTY_MIN);
              dt_d   = dt_clamped;
            end
          end
        end
        FAULT: begin
          duty_d   = '0;
          dt_d     = '0;
          pwm_en_d = 1'b0;
          if (fault_clear && !enable) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench for pwm_duty_sequencer: driver queues expected outputs per period_start/fault,
// a monitor pops and compares them on the following falling edge.
module tb_pwm_duty_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       fault = 1'b0;
  logic       fault_clear = 1'b0;
  logic       period_start = 1'b0;
  logic [9:0] target_duty = '0;
  logic       target_valid = 1'b0;
  logic       target_ready;
  logic [8:0] dead_time_cfg = 9'd20;
  logic [9:0] duty_data;
  logic [8:0] dead_time;
  logic       pwm_en;
  logic [2:0] state;
  logic       fault_latched;

  localparam logic [2:0] S_IDLE = 3'd0, S_SS = 3'd1, S_RUN = 3'd2, S_SD = 3'd3, S_FLT = 3'd4;

  typedef struct {
    logic [9:0] duty;
    logic [8:0] dt;
    logic       pwm;
    logic [2:0] st;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pwm_duty_sequencer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fault(fault),
    .fault_clear(fault_clear), .period_start(period_start),
    .target_duty(target_duty), .target_valid(target_valid),
    .target_ready(target_ready), .dead_time_cfg(dead_time_cfg),
    .duty_data(duty_data), .dead_time(dead_time), .pwm_en(pwm_en),
    .state(state), .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, queue depth %0d, required 0", sb_q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: an output update is presented on any edge sampling period_start or fault.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (reset_n && (period_start === 1'b1 || fault === 1'b1)) begin
        @(negedge clk);
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got duty=%0d dt=%0d pwm=%0b st=%0d, required no update",
                   duty_data, dead_time, pwm_en, state);
        end else begin
          e = sb_q.pop_front();
          if (duty_data !== e.duty || dead_time !== e.dt || pwm_en !== e.pwm || state !== e.st) begin
            n_fail++;
            $display("FAIL sb_out @%0t: got duty=%0d dt=%0d pwm=%0b st=%0d, required duty=%0d dt=%0d pwm=%0b st=%0d",
                     $time, duty_data, dead_time, pwm_en, state, e.duty, e.dt, e.pwm, e.st);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic push(input int d, input int dt, input int p, input int st);
    exp_t e;
    e.duty = 10'(d); e.dt = 9'(dt); e.pwm = 1'(p); e.st = 3'(st);
    sb_q.push_back(e);
  endtask

  task automatic pulse(input int d, input int dt, input int p, input int st);
    period_start = 1'b1;
    push(d, dt, p, st);
    @(negedge clk);
    period_start = 1'b0;
  endtask

  task automatic send_target(input int v);
    target_valid = 1'b1;
    target_duty  = 10'(v);
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    #3;
    check("rst_duty", duty_data, 0);
    check("rst_dt", dead_time, 0);
    check("rst_pwm", pwm_en, 0);
    check("rst_state", state, S_IDLE);
    check("rst_flt", fault_latched, 0);
    check("rst_ready", target_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Soft-start to 300: 100, 104, ... reaching 300 on the 51st period_start
    send_target(300);
    enable = 1'b1;
    @(negedge clk);
    check("ss_state", state, S_SS);
    for (int k = 0; k <= 50; k++) pulse(100 + 4 * k, 20, 1, (k == 50) ? S_RUN : S_SS);

    // Small step lands exactly; dead time clamps to 82
    dead_time_cfg = 9'd200;
    send_target(302);
    pulse(302, 82, 1, S_RUN);
    send_target(300);
    pulse(300, 82, 1, S_RUN);

    // 300 -> 200 in 25 steps
    send_target(200);
    for (int k = 1; k <= 25; k++) pulse(300 - 4 * k, 82, 1, S_RUN);

    // target 1000 clamps to 500
    send_target(1000);
    for (int k = 1; k <= 75; k++) pulse(200 + 4 * k, 82, 1, S_RUN);
    pulse(500, 82, 1, S_RUN);

    // target 10 clamps to 100; back-to-back period_start pulses
    send_target(10);
    period_start = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      push((k <= 100) ? 500 - 4 * k : 100, 82, 1, S_RUN);
      @(negedge clk);
    end
    period_start = 1'b0;

    send_target(120);
    for (int k = 1; k <= 5; k++) pulse(100 + 4 * k, 82, 1, S_RUN);

    // tgt written alongside period_start is not used until the next one
    target_valid = 1'b1;
    target_duty  = 10'd140;
    pulse(120, 82, 1, S_RUN);
    target_valid = 1'b0;
    pulse(124, 82, 1, S_RUN);
    send_target(120);
    pulse(120, 82, 1, S_RUN);

    // Soft-stop from 120
    enable = 1'b0;
    @(negedge clk);
    check("sd_state", state, S_SD);
    for (int k = 1; k <= 5; k++) pulse(120 - 4 * k, 82, 1, S_SD);
    pulse(0, 0, 0, S_IDLE);

    // Re-enable during shutdown at 108 continues from 108
    enable = 1'b1;
    @(negedge clk);
    pulse(100, 82, 1, S_SS);
    pulse(104, 82, 1, S_SS);
    pulse(108, 82, 1, S_SS);
    enable = 1'b0;
    @(negedge clk);
    check("sd2_state", state, S_SD);
    enable = 1'b1;
    @(negedge clk);
    check("ss2_state", state, S_SS);
    pulse(112, 82, 1, S_SS);
    pulse(116, 82, 1, S_SS);
    pulse(120, 82, 1, S_RUN);

    // Up to 300 then fault coincident with period_start and a target transfer
    send_target(300);
    for (int k = 1; k <= 45; k++) pulse(120 + 4 * k, 82, 1, S_RUN);
    fault        = 1'b1;
    target_valid = 1'b1;
    target_duty  = 10'd100;
    period_start = 1'b1;
    push(0, 0, 0, S_FLT);
    #1;
    check("flt_ready_comb", target_ready, 0);
    @(negedge clk);
    fault        = 1'b0;
    target_valid = 1'b0;
    period_start = 1'b0;
    check("flt_latched", fault_latched, 1);
    check("flt_ready", target_ready, 0);

    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    check("flt_clear_en", state, S_FLT);
    enable = 1'b0;
    @(negedge clk);
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    check("flt_clear_idle", state, S_IDLE);
    check("flt_clear_latched", fault_latched, 0);

    // tgt must still be 300: first period stays SOFTSTART at 100
    enable = 1'b1;
    @(negedge clk);
    pulse(100, 82, 1, S_SS);
    pulse(104, 82, 1, S_SS);
    send_target(108);
    pulse(108, 82, 1, S_RUN);

    // Async reset at a non-clock instant
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_duty", duty_data, 0);
    check("arst_dt", dead_time, 0);
    check("arst_pwm", pwm_en, 0);
    check("arst_state", state, S_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sb_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

Sequences and protects the complementary dead-time PWM generator in the voltage-control loop. Accepts duty targets from the PID stage over a valid/ready handshake, clamps them, and slew-limits the applied duty one step per PWM period. It also runs soft-start and soft-stop, and forces the outputs off on a fault. All updates to the generator's duty and dead-time inputs land only on PWM period boundaries, so a period never sees a mid-cycle change.

## Interface
- DUTY_MIN, 10'd100, lowest duty applied while running; also the soft-start and soft-stop floor.
- DUTY_MAX, 10'd500, highest duty applied.
- STEP, 10'd4, maximum duty change per period. Must be ≥ 1.
- DT_MAX, 9'd82, dead-time ceiling. Constraint: DT_MAX < DUTY_MIN.
- clk  in  1  system clock; all registers are on the posedge.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level request to run the converter.
- fault  in  1  level over-current / over-voltage flag, synchronous to clk.
- fault_clear  in  1  single-cycle pulse that leaves FAULT.
- period_start  in  1  single-cycle pulse, one clk wide, at each PWM counter wrap.
- target_duty  in  10  requested duty from PID.
- target_valid  in  1  target_duty is valid.
- target_ready  out  1  combinational: (state != FAULT) && !fault.
- dead_time_cfg  in  9  requested dead time.
- duty_data  out  10  duty to the PWM generator.
- dead_time  out  9  dead time to the PWM generator.
- pwm_en  out  1  gate for both PWM outputs; 0 forces both low.
- state  out  3  IDLE=0, SOFTSTART=1, RUN=2, SHUTDOWN=3, FAULT=4.
- fault_latched  out  1  high while in FAULT.

## Operation
- Target register (tgt)
  - Loads clamp(target_duty, DUTY_MIN, DUTY_MAX) on any cycle where target_valid && target_ready.
  - Holds its value otherwise.
- Dead time
  - Loads min(dead_time_cfg, DT_MAX) on each period_start while in SOFTSTART, RUN or SHUTDOWN.
  - Is 0 in IDLE and FAULT.
- Slew rule on period_start, toward goal g:
  - if |g − duty_data| ≤ STEP, duty_data = g;
  - otherwise duty_data moves STEP toward g.
  - Compute with an 11-bit signed difference, so there is no wrap.
- State transitions
  - IDLE: duty_data=0, pwm_en=0. On enable=1 → SOFTSTART.
  - SOFTSTART: on the first period_start, duty_data=DUTY_MIN and pwm_en=1. On later period_starts, slew toward tgt. Go to RUN on the period_start where duty_data reaches tgt. enable=0 → SHUTDOWN.
  - RUN: on each period_start, slew toward tgt. enable=0 → SHUTDOWN.
  - SHUTDOWN: on each period_start, slew toward DUTY_MIN. On a period_start with duty_data already equal to DUTY_MIN, set duty_data=0, dead_time=0, pwm_en=0 and go to IDLE. enable=1 → SOFTSTART, continuing from the current duty with no reset to DUTY_MIN.
  - FAULT: duty_data=0, dead_time=0, pwm_en=0. Go to IDLE on fault_clear && !fault && !enable. fault_clear is ignored otherwise.
- Fault priority
  - fault=1 in any state → FAULT at the next clk edge, without waiting for period_start.
  - Fault takes priority over enable, target handshake and period_start in the same cycle.

## Timing
- Reset values: duty_data=0, dead_time=0, pwm_en=0, state=IDLE, fault_latched=0, tgt=DUTY_MIN.
- Reset mid-operation: all outputs drop to their reset values asynchronously.
- Output latency: duty_data, dead_time and pwm_en change only on the clk edge that samples period_start=1. The exception is fault, which acts on the first edge with fault=1.
- Fault latency: 1 clk from fault high to pwm_en=0.
- Handshake: a transfer happens on an edge with target_valid && target_ready. A tgt written in the same cycle as period_start is not used until the next period_start, because the slew uses the old tgt.
- Enable timing: enable changes take effect at the next clk edge. Duty motion still waits for period_start.
- Back-to-back period_start on consecutive cycles is legal. Each pulse applies one slew step.

## Test plan
- Soft-start: tgt=300, STEP=4, enable=1 → duty 100, 104, … on successive period_starts; reaches 300 on the 51st period_start; state=RUN; pwm_en=1 from the first period_start.
- Clamp and dead time: target_duty=1000 → tgt=500. target_duty=10 → tgt=100. dead_time_cfg=200 → dead_time=82 at the next period_start.
- Slew in RUN: duty 300, new tgt=302 → 302 after one period_start. New tgt=200 → 296, 292, …, 200 after 25 period_starts.
- Soft-stop: enable=0 at duty 120 → 116, …, 100, then duty 0, pwm_en=0, state=IDLE on the following period_start. Re-asserting enable at duty 108 → SOFTSTART continues from 108.
- Fault: fault=1 in RUN at duty 300, coincident with period_start and target_valid → next edge pwm_en=0, duty 0, state=FAULT, target_ready=0, tgt unchanged. fault_clear while enable=1 → stays in FAULT. enable=0, fault=0, fault_clear → IDLE.
- Async reset mid-RUN: reset_n low at a non-clock instant → all outputs at reset values immediately.
